// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forwarding sequencing for the RV32I 5-stage pipeline.
// Optional macro HAZARD_FORWARDING_EN: EX-stage forwarding on, stalls only for load-use.
module hazard_controller #(
   parameter int unsigned WAIT_LIMIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_id,
   input  logic [4:0]  rs2_id,
   input  logic        rs1_used_id,
   input  logic        rs2_used_id,
   input  logic [4:0]  rs1_ex,
   input  logic [4:0]  rs2_ex,
   input  logic [4:0]  rd_ex,
   input  logic        reg_write_ex,
   input  logic        load_ex,
   input  logic [4:0]  rd_mem,
   input  logic        reg_write_mem,
   input  logic [4:0]  rd_wb,
   input  logic        reg_write_wb,
   input  logic        branch_taken_ex,
   input  logic        dmem_req_mem,
   input  logic        dmem_ready,
   output logic        stall_if,
   output logic        stall_id,
   output logic        flush_id,
   output logic        flush_ex,
   output logic        freeze,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic        mem_timeout,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
);

   localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(WAIT_LIMIT);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          timeout_q, timeout_d;
   logic [31:0]   stall_cnt_q, stall_cnt_d;
   logic [31:0]   flush_cnt_q, flush_cnt_d;

   logic freeze_s;
   logic hz_ex_s;
   logic data_hz_s;

   // A producer only matters when it writes a nonzero register that ID really reads.
   function automatic logic dep_on(input logic [4:0] rd, input logic we,
                                   input logic [4:0] s1, input logic u1,
                                   input logic [4:0] s2, input logic u2);
      return we && (rd != 5'd0) && ((u1 && (s1 == rd)) || (u2 && (s2 == rd)));
   endfunction

   assign freeze_s = dmem_req_mem & ~dmem_ready;
   assign hz_ex_s  = dep_on(rd_ex, reg_write_ex, rs1_id, rs1_used_id, rs2_id, rs2_used_id);

`ifdef HAZARD_FORWARDING_EN
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rdm, input logic wem,
                                          input logic [4:0] rdw, input logic wew);
      if (rs == 5'd0) begin
         return 2'b00;
      end else if (wem && (rdm == rs)) begin
         return 2'b01;
      end else if (wew && (rdw == rs)) begin
         return 2'b10;
      end else begin
         return 2'b00;
      end
   endfunction

   assign data_hz_s = hz_ex_s & load_ex;

   // Operand source selection for the EX-stage muxes
   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (!rst) begin
         fwd_a_sel = fwd_sel(rs1_ex, rd_mem, reg_write_mem, rd_wb, reg_write_wb);
         fwd_b_sel = fwd_sel(rs2_ex, rd_mem, reg_write_mem, rd_wb, reg_write_wb);
      end else begin
         fwd_a_sel = 2'b00;
         fwd_b_sel = 2'b00;
      end
   end
`else
   logic unused_fwd_s;
   assign unused_fwd_s = ^{load_ex, rs1_ex, rs2_ex, rd_wb, reg_write_wb};

   // Without forwarding the consumer waits until the producer has left MEM
   assign data_hz_s = hz_ex_s
                    | dep_on(rd_mem, reg_write_mem, rs1_id, rs1_used_id, rs2_id, rs2_used_id);

   // Forwarding muxes always read the register file in this build
   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
   end
`endif

   // Prioritised stall/flush decision; reset forces bubbles into IF/ID and ID/EX
   always_comb begin
      stall_if = 1'b0;
      stall_id = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      freeze   = 1'b0;
      if (rst) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
      end else if (freeze_s) begin
         freeze = 1'b1;
      end else if (branch_taken_ex) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
      end else if (data_hz_s) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
         flush_ex = 1'b1;
      end else begin
         stall_if = 1'b0;
      end
   end

   // Memory-wait FSM, timeout detection and performance counter next state
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      stall_cnt_d = stall_cnt_q + ((stall_id | freeze) ? 32'd1 : 32'd0);
      flush_cnt_d = flush_cnt_q + ((branch_taken_ex & ~freeze_s) ? 32'd1 : 32'd0);
      case (state_q)
         ST_RUN: begin
            wait_cnt_d = '0;
            if (freeze_s) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_WAIT: begin
            if (dmem_ready) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else if (freeze_s) begin
               if (wait_cnt_q != LIMIT_C) begin
                  wait_cnt_d = wait_cnt_q + CW'(1);
               end else begin
                  wait_cnt_d = wait_cnt_q;
               end
               if (wait_cnt_d == LIMIT_C) begin
                  timeout_d = 1'b1;
               end else begin
                  timeout_d = timeout_q;
               end
            end else begin
               wait_cnt_d = wait_cnt_q;
            end
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Registered FSM state, sticky error and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign mem_timeout  = timeout_q;
   assign stall_cycles = stall_cnt_q;
   assign flush_events = flush_cnt_q;

endmodule
